odo_beat_counter: RTL and testbench



---
 rtl/odo_beat_counter.sv | 173 +++++++++++++++++
 tb/tb_odo_beat_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/odo_beat_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : odo_beat_counter
// Purpose  : Gates one stress/reference ring-oscillator pair and counts each
//            ring's rising edges over a programmable window. Optional DIFF
//            subtractor is built when ODO_BEAT_DIFF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module odo_beat_counter #(
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic             i_osc_stress,
    input  logic             i_osc_ref,
    output logic             o_osc_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt_stress,
    output logic [CNT_W-1:0] o_cnt_ref,
    output logic [CNT_W:0]   o_diff,
    output logic             o_ovf
);

    localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [SET_W-1:0]   r_settle;
    logic [WIN_W-1:0]   r_win;

    logic               r_s_meta, r_s_sync, r_s_hist;
    logic               r_r_meta, r_r_sync, r_r_hist;

    logic               w_s_rise, w_r_rise;
    logic               w_s_inc, w_r_inc;
    logic               w_s_sat, w_r_sat;
    logic [CNT_W-1:0]   w_s_nxt, w_r_nxt;
    logic               w_ovf_nxt;
    logic               w_accept;
    logic               w_to_done;

    // Synchronisers run continuously so edge history is always current
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_meta <= 1'b0;
            r_s_sync <= 1'b0;
            r_s_hist <= 1'b0;
            r_r_meta <= 1'b0;
            r_r_sync <= 1'b0;
            r_r_hist <= 1'b0;
        end else begin
            r_s_meta <= i_osc_stress;
            r_s_sync <= r_s_meta;
            r_s_hist <= r_s_sync;
            r_r_meta <= i_osc_ref;
            r_r_sync <= r_r_meta;
            r_r_hist <= r_r_sync;
        end
    end

    assign w_s_rise  = r_s_sync & ~r_s_hist;
    assign w_r_rise  = r_r_sync & ~r_r_hist;

    assign w_s_inc   = (r_state == S_MEASURE) && w_s_rise;
    assign w_r_inc   = (r_state == S_MEASURE) && w_r_rise;
    assign w_s_sat   = &o_cnt_stress;
    assign w_r_sat   = &o_cnt_ref;
    assign w_s_nxt   = (w_s_inc && !w_s_sat) ? o_cnt_stress + CNT_W'(1) : o_cnt_stress;
    assign w_r_nxt   = (w_r_inc && !w_r_sat) ? o_cnt_ref + CNT_W'(1) : o_cnt_ref;
    assign w_ovf_nxt = o_ovf | (w_s_inc & w_s_sat) | (w_r_inc & w_r_sat);

    assign w_accept  = (r_state == S_IDLE) && i_start;
    assign w_to_done = ((r_state == S_SETTLE) && (r_settle == SET_W'(1)) && (r_win == '0)) ||
                       ((r_state == S_MEASURE) && (r_win == WIN_W'(1)));

    // OSC_EN drops on entry to DONE; BUSY drops on leaving it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle     <= '0;
            r_win        <= '0;
            o_osc_en     <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_cnt_stress <= '0;
            o_cnt_ref    <= '0;
            o_ovf        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_SETTLE;
                        r_settle     <= SET_W'(SETTLE_CYC);
                        r_win        <= i_win_len;
                        o_cnt_stress <= '0;
                        o_cnt_ref    <= '0;
                        o_ovf        <= 1'b0;
                        o_osc_en     <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == SET_W'(1)) begin
                        if (w_to_done) begin
                            r_state  <= S_DONE;
                            o_done   <= 1'b1;
                            o_osc_en <= 1'b0;
                        end else begin
                            r_state  <= S_MEASURE;
                        end
                    end else begin
                        r_settle <= r_settle - SET_W'(1);
                    end
                end
                S_MEASURE: begin
                    o_cnt_stress <= w_s_nxt;
                    o_cnt_ref    <= w_r_nxt;
                    o_ovf        <= w_ovf_nxt;
                    r_win        <= r_win - WIN_W'(1);
                    if (w_to_done) begin
                        r_state  <= S_DONE;
                        o_done   <= 1'b1;
                        o_osc_en <= 1'b0;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ODO_BEAT_DIFF_EN
    logic [CNT_W:0] r_diff;
    logic [CNT_W:0] w_diff_nxt;

    // Uses the post-increment counts so DIFF is valid alongside DONE
    assign w_diff_nxt = {1'b0, w_s_nxt} - {1'b0, w_r_nxt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
        end else if (w_accept) begin
            r_diff <= '0;
        end else if (w_to_done) begin
            r_diff <= w_diff_nxt;
        end
    end

    assign o_diff = r_diff;
`else
    assign o_diff = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_odo_beat_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_odo_beat_counter
// Purpose  : Directed self-checking bench for odo_beat_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odo_beat_counter;

`ifdef ODO_BEAT_DIFF_EN
    localparam bit DIFF_ON = 1'b1;
`else
    localparam bit DIFF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_win_len = 16'd0;
    logic        osc_s = 1'b0;
    logic        osc_r = 1'b0;
    logic        sat_osc_s = 1'b0;
    logic        sat_osc_r = 1'b0;

    logic        o_osc_en, o_busy, o_done, o_ovf;
    logic [15:0] o_cnt_s, o_cnt_r;
    logic [16:0] o_diff;

    logic        s_osc_en, s_busy, s_done, s_ovf;
    logic [3:0]  s_cnt_s, s_cnt_r;
    logic [4:0]  s_diff;

    int p_stress = 4;
    int p_ref    = 5;
    int ph_s = 0, ph_r = 0, ph_sat = 0;

    int n_vec  = 0;
    int n_fail = 0;

    int   done_at, s_done_at, en_cyc, n_done;
    logic busy_at_done;

    always #5 clk = ~clk;

    odo_beat_counter #(.SETTLE_CYC(8), .CNT_W(16), .WIN_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_win_len    (i_win_len),
        .i_osc_stress (osc_s),
        .i_osc_ref    (osc_r),
        .o_osc_en     (o_osc_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cnt_stress (o_cnt_s),
        .o_cnt_ref    (o_cnt_r),
        .o_diff       (o_diff),
        .o_ovf        (o_ovf)
    );

    odo_beat_counter #(.SETTLE_CYC(8), .CNT_W(4), .WIN_W(16)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_win_len    (i_win_len),
        .i_osc_stress (sat_osc_s),
        .i_osc_ref    (sat_osc_r),
        .o_osc_en     (s_osc_en),
        .o_busy       (s_busy),
        .o_done       (s_done),
        .o_cnt_stress (s_cnt_s),
        .o_cnt_ref    (s_cnt_r),
        .o_diff       (s_diff),
        .o_ovf        (s_ovf)
    );

    // Ring models: run only while enabled, restart from phase 0
    always @(posedge clk) begin
        #2;
        if (o_osc_en) begin
            osc_s = (ph_s < p_stress / 2);
            osc_r = (ph_r < p_ref / 2);
            ph_s  = (ph_s + 1) % p_stress;
            ph_r  = (ph_r + 1) % p_ref;
        end else begin
            osc_s = 1'b0;
            osc_r = 1'b0;
            ph_s  = 0;
            ph_r  = 0;
        end
        if (s_osc_en) begin
            sat_osc_s = (ph_sat == 0);
            ph_sat    = (ph_sat + 1) % 2;
        end else begin
            sat_osc_s = 1'b0;
            ph_sat    = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Issues one START, then observes n_cyc cycles; extra START pulses at st1/st2
    task automatic measure(input logic [15:0] win, input int n_cyc, input int st1, input int st2);
        done_at      = -1;
        s_done_at    = -1;
        en_cyc       = 0;
        n_done       = 0;
        busy_at_done = 1'b0;
        i_win_len = win;
        i_start   = 1'b1;
        @(posedge clk); #1;
        i_start   = 1'b0;
        i_win_len = 16'hFFFF;
        for (int k = 1; k <= n_cyc; k++) begin
            if (o_osc_en) en_cyc++;
            if (o_done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at      = k;
                    busy_at_done = o_busy;
                end
            end
            if (s_done && s_done_at < 0) s_done_at = k;
            i_start = (k == st1) || (k == st2);
            @(posedge clk); #1;
        end
        i_start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_osc_en", o_osc_en, 0);
        chk("rst_busy",   o_busy,   0);
        chk("rst_done",   o_done,   0);
        chk("rst_cnt_s",  o_cnt_s,  0);
        chk("rst_cnt_r",  o_cnt_r,  0);
        chk("rst_diff",   o_diff,   0);
        chk("rst_ovf",    o_ovf,    0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", o_busy, 0);

        // Basic measurement
        measure(16'd100, 115, 0, 0);
        chk("basic_done_at",   done_at, 109);
        chk("basic_en_cyc",    en_cyc, 108);
        chk("basic_n_done",    n_done, 1);
        chk("basic_busy_done", busy_at_done, 1);
        chk("basic_cnt_s",     o_cnt_s, 25);
        chk("basic_cnt_r",     o_cnt_r, 20);
        chk("basic_diff",      o_diff, DIFF_ON ? 32'd5 : 32'd0);
        chk("basic_ovf",       o_ovf, 0);
        chk("basic_busy_after", o_busy, 0);
        chk("basic_en_after",  o_osc_en, 0);

        // Saturation on the 4-bit instance
        measure(16'd64, 80, 0, 0);
        chk("sat_done_at",  s_done_at, 73);
        chk("sat_main_done", done_at, 73);
        chk("sat_cnt_s",    s_cnt_s, 15);
        chk("sat_cnt_r",    s_cnt_r, 0);
        chk("sat_ovf",      s_ovf, 1);
        chk("sat_diff",     s_diff, DIFF_ON ? 32'd15 : 32'd0);
        chk("nosat_ovf",    o_ovf, 0);

        // Zero window; also clears the sticky OVF on the saturating instance
        measure(16'd0, 20, 0, 0);
        chk("zero_done_at", done_at, 9);
        chk("zero_en_cyc",  en_cyc, 8);
        chk("zero_cnt_s",   o_cnt_s, 0);
        chk("zero_cnt_r",   o_cnt_r, 0);
        chk("zero_diff",    o_diff, 0);
        chk("zero_sat_ovf", s_ovf, 0);
        chk("zero_sat_cnt", s_cnt_s, 0);

        // Reference faster than stress: negative difference
        p_stress = 5;
        p_ref    = 4;
        measure(16'd100, 115, 0, 0);
        chk("neg_cnt_s", o_cnt_s, 20);
        chk("neg_cnt_r", o_cnt_r, 25);
        chk("neg_diff",  o_diff, DIFF_ON ? 32'h1FFFB : 32'd0);
        p_stress = 4;
        p_ref    = 5;

        // Busy interlock: extra STARTs in SETTLE and MEASURE
        measure(16'd100, 130, 4, 50);
        chk("lock_n_done",  n_done, 1);
        chk("lock_done_at", done_at, 109);
        chk("lock_cnt_s",   o_cnt_s, 25);
        chk("lock_cnt_r",   o_cnt_r, 20);
        chk("lock_busy",    o_busy, 0);

        // Reset in the middle of MEASURE
        i_win_len = 16'd100;
        i_start   = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("mid_busy_pre", o_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_osc_en", o_osc_en, 0);
        chk("mid_busy",   o_busy, 0);
        chk("mid_done",   o_done, 0);
        chk("mid_cnt_s",  o_cnt_s, 0);
        chk("mid_cnt_r",  o_cnt_r, 0);
        chk("mid_diff",   o_diff, 0);
        chk("mid_ovf",    o_ovf, 0);
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (o_done) n_done++;
        end
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (o_done) n_done++;
        end
        chk("mid_no_done", n_done, 0);
        measure(16'd100, 115, 0, 0);
        chk("post_done_at", done_at, 109);
        chk("post_cnt_s",   o_cnt_s, 25);
        chk("post_cnt_r",   o_cnt_r, 20);
        chk("post_diff",    o_diff, DIFF_ON ? 32'd5 : 32'd0);

        // Results hold in IDLE
        repeat (5) @(posedge clk);
        #1;
        chk("hold_cnt_s", o_cnt_s, 25);
        chk("hold_diff",  o_diff, DIFF_ON ? 32'd5 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
